pwm_fade_ctrl: RTL and testbench

Sequencer for the 16-bit PWM block (counter, compare register, top register loaded over a shared `sel`/`d` bus). It accepts a fade command, programs the period, restarts the counter, and ramps the compare value toward a target duty. Each compare write lands exactly on a period boundary, so no PWM period sees a partial update. It sits between the software-facing command interface and the PWM block's `sel`/`d` load port.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_fade_ctrl_if.sv | 30 +++
 rtl/pwm_duty_step.sv | 29 ++
 rtl/pwm_fade_ctrl.sv | 120 ++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared encodings for the PWM fade sequencer: load-select codes and FSM states.
package pwm_pkg;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_CMP  = 2'b01;
    localparam logic [1:0] SEL_TOP  = 2'b10;
    localparam logic [1:0] SEL_CNT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LD_TOP,
        LD_CNT,
        RAMP
    } fade_state_t;

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Command handshake plus the PWM block's status and load bus, as seen by the fade sequencer.
interface pwm_fade_ctrl_if #(
    parameter int W    = 16,
    parameter int DIVW = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [W-1:0]    cmd_top;
    logic [W-1:0]    cmd_target;
    logic [W-1:0]    cmd_step;
    logic [DIVW-1:0] cmd_div;
    logic [W-1:0]    cnt;
    logic [W-1:0]    top;
    logic [1:0]      sel;
    logic [W-1:0]    d;
    logic            busy;
    logic            done;

    // Host side: issues commands and reflects the PWM counter/top registers.
    modport master (
        output cmd_valid, cmd_top, cmd_target, cmd_step, cmd_div, cnt, top,
        input  cmd_ready, sel, d, busy, done
    );

    // Fade sequencer side.
    modport slave (
        input  cmd_valid, cmd_top, cmd_target, cmd_step, cmd_div, cnt, top,
        output cmd_ready, sel, d, busy, done
    );
endinterface

// File: rtl/pwm_duty_step.sv
// Next compare value for one ramp step: moves cur toward tgt by step, clamped at tgt.
module pwm_duty_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] tgt,
    input  logic [W-1:0] step,
    output logic [W-1:0] nxt
);

    logic [W:0] sum;
    logic [W:0] gap;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        nxt = tgt;
        sum = {1'b0, cur} + {1'b0, step};
        gap = {1'b0, cur} - {1'b0, tgt};
        if (step != '0 && cur != tgt) begin
            if (cur < tgt) begin
                // The extra bit keeps cur+step from wrapping past the top of the range.
                nxt = (sum >= {1'b0, tgt}) ? tgt : sum[W-1:0];
            end else begin
                nxt = ({1'b0, step} >= gap) ? tgt : cur - step;
            end
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer: programs PWM top, restarts the counter, then ramps the compare
// register toward the target with every write aligned to a period boundary.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int W    = 16,
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            rst,
    pwm_fade_ctrl_if.slave  bus
);

    fade_state_t     state;
    fade_state_t     state_nxt;
    logic [W-1:0]    top_r;
    logic [W-1:0]    tgt_r;
    logic [W-1:0]    step_r;
    logic [DIVW-1:0] div_r;
    logic [DIVW-1:0] div_cnt;
    logic [W-1:0]    cur;
    logic [W-1:0]    nxt;
    logic            done_r;

    logic            accept;
    logic            boundary;
    logic            load_cmp;
    logic            dec_div;
    logic            finish;
    logic [1:0]      sel;
    logic [W-1:0]    d;

    pwm_duty_step #(.W(W)) u_step (
        .cur  (cur),
        .tgt  (tgt_r),
        .step (step_r),
        .nxt  (nxt)
    );

    assign accept   = bus.cmd_valid && (state == IDLE);
    assign boundary = bus.cnt >= bus.top;

    always_comb begin
        state_nxt = state;
        sel       = SEL_NONE;
        d         = '0;
        load_cmp  = 1'b0;
        dec_div   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (bus.cmd_top != bus.top) ? LD_TOP : RAMP;
                end
            end
            LD_TOP: begin
                sel       = SEL_TOP;
                d         = top_r;
                state_nxt = LD_CNT;
            end
            LD_CNT: begin
                sel       = SEL_CNT;
                state_nxt = RAMP;
            end
            RAMP: begin
                // Compare loads are Mealy on the boundary so they land on the counter wrap edge.
                if (boundary) begin
                    if (div_cnt != '0) begin
                        dec_div = 1'b1;
                    end else begin
                        sel      = SEL_CMP;
                        d        = nxt;
                        load_cmp = 1'b1;
                        if (nxt == tgt_r) begin
                            finish    = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            top_r   <= '0;
            tgt_r   <= '0;
            step_r  <= '0;
            div_r   <= '0;
            div_cnt <= '0;
            cur     <= '0;
            done_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= finish;
            if (accept) begin
                top_r   <= bus.cmd_top;
                tgt_r   <= bus.cmd_target;
                step_r  <= bus.cmd_step;
                div_r   <= bus.cmd_div;
                div_cnt <= '0;
            end else if (load_cmp) begin
                cur     <= nxt;
                div_cnt <= div_r;
            end else if (dec_div) begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end

    assign bus.sel       = sel;
    assign bus.d         = d;
    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl with a behavioural PWM counter/top/compare block.
module tb_pwm_fade_ctrl;
    import pwm_pkg::*;

    localparam int W      = 16;
    localparam int DIVW   = 8;
    localparam int BUDGET = 2000;

    typedef struct packed {
        logic [W-1:0]       top;
        logic [W-1:0]       target;
        logic [W-1:0]       step;
        logic [DIVW-1:0]    div;
        bit                 top_load;
        int                 n_writes;
        logic [3:0][W-1:0]  w;
        int                 first_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pwm_fade_ctrl_if #(.W(W), .DIVW(DIVW)) bus ();

    pwm_fade_ctrl #(.W(W), .DIVW(DIVW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural PWM block: counts 0..top, wraps, and honours sel/d loads.
    logic [W-1:0] pwm_cnt = '0;
    logic [W-1:0] pwm_top = '0;
    logic [W-1:0] pwm_cmp = '0;

    always @(posedge clk) begin
        if (bus.sel == SEL_TOP) pwm_top <= bus.d;
        if (bus.sel == SEL_CMP) pwm_cmp <= bus.d;
        if (bus.sel == SEL_CNT)      pwm_cnt <= bus.d;
        else if (pwm_cnt >= pwm_top) pwm_cnt <= '0;
        else                         pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign bus.cnt = pwm_cnt;
    assign bus.top = pwm_top;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int top, input int target, input int step, input int div,
                                input bit tl, input int n, input int w0, input int w1,
                                input int w2, input int w3, input int first);
        vec_t v;
        v.top       = W'(top);
        v.target    = W'(target);
        v.step      = W'(step);
        v.div       = DIVW'(div);
        v.top_load  = tl;
        v.n_writes  = n;
        v.w[0]      = W'(w0);
        v.w[1]      = W'(w1);
        v.w[2]      = W'(w2);
        v.w[3]      = W'(w3);
        v.first_cyc = first;
        return v;
    endfunction

    task automatic drive_cmd(input vec_t v);
        bus.cmd_top    = v.top;
        bus.cmd_target = v.target;
        bus.cmd_step   = v.step;
        bus.cmd_div    = v.div;
        bus.cmd_valid  = 1'b1;
    endtask

    // Issues one command and checks every load/write it produces up to the done pulse.
    task automatic run_vec(input vec_t v, input string tag);
        int           cyc;
        int           nw;
        int           first_w;
        int           last_w;
        int           done_cyc;
        int           n_top;
        int           n_cnt;
        int           exp_gap;
        bit           order_ok;
        bit           phase_ok;
        bit           gap_ok;
        bit           busy_ok;
        logic [W-1:0] got [4];
        cyc = 0; nw = 0; first_w = 0; last_w = 0; done_cyc = 0; n_top = 0; n_cnt = 0;
        order_ok = 1'b1; phase_ok = 1'b1; gap_ok = 1'b1; busy_ok = 1'b1;
        for (int i = 0; i < 4; i++) got[i] = '0;
        exp_gap = (int'(v.div) + 1) * (int'(v.top) + 1);

        @(negedge clk);
        drive_cmd(v);
        check({tag, " ready"}, 32'(bus.cmd_ready), 32'd1);
        while (done_cyc == 0 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) bus.cmd_valid = 1'b0;
            if (bus.done) begin
                done_cyc = cyc;
            end else begin
                if (!bus.busy) busy_ok = 1'b0;
                case (bus.sel)
                    SEL_TOP: begin
                        n_top++;
                        if (cyc != 1 || bus.d != v.top) order_ok = 1'b0;
                    end
                    SEL_CNT: begin
                        n_cnt++;
                        if (cyc != 2 || bus.d != '0) order_ok = 1'b0;
                    end
                    SEL_CMP: begin
                        if (nw < 4) got[nw] = bus.d;
                        if (bus.cnt < bus.top) phase_ok = 1'b0;
                        if (nw == 0) first_w = cyc;
                        else if (cyc - last_w != exp_gap) gap_ok = 1'b0;
                        last_w = cyc;
                        nw++;
                    end
                    default: ;
                endcase
            end
        end

        check({tag, " done_seen"}, 32'(done_cyc != 0), 32'd1);
        check({tag, " top_loads"}, 32'(n_top), 32'(v.top_load));
        check({tag, " cnt_loads"}, 32'(n_cnt), 32'(v.top_load));
        check({tag, " load_order"}, 32'(order_ok), 32'd1);
        check({tag, " n_writes"}, 32'(nw), 32'(v.n_writes));
        for (int i = 0; i < v.n_writes; i++)
            check($sformatf("%s write%0d", tag, i), 32'(got[i]), 32'(v.w[i]));
        check({tag, " write_on_boundary"}, 32'(phase_ok), 32'd1);
        check({tag, " write_spacing"}, 32'(gap_ok), 32'd1);
        check({tag, " busy_held"}, 32'(busy_ok), 32'd1);
        if (v.first_cyc != 0) check({tag, " first_write_cyc"}, 32'(first_w), 32'(v.first_cyc));
        check({tag, " done_after_last"}, 32'(done_cyc), 32'(last_w + 1));
        check({tag, " ready_with_done"}, 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    vec_t vecs [6];

    initial begin
        int           cyc;
        int           nw;
        int           n_top;
        int           n_stray;
        int           early_ready;
        logic [W-1:0] last_d;
        bit           seen;

        vecs[0] = mk(99, 40, 10, 0, 1'b1, 4, 10, 20, 30, 40, 102);
        vecs[1] = mk(99, 5, 20, 1, 1'b0, 2, 20, 5, 0, 0, 0);
        vecs[2] = mk(99, 1234, 0, 0, 1'b0, 1, 1234, 0, 0, 0, 0);
        vecs[3] = mk(99, 65530, 0, 0, 1'b0, 1, 65530, 0, 0, 0, 0);
        vecs[4] = mk(99, 65535, 100, 0, 1'b0, 1, 65535, 0, 0, 0, 0);
        vecs[5] = mk(0, 65533, 1, 2, 1'b1, 2, 65534, 65533, 0, 0, 3);

        bus.cmd_valid  = 1'b0;
        bus.cmd_top    = '0;
        bus.cmd_target = '0;
        bus.cmd_step   = '0;
        bus.cmd_div    = '0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset sel", 32'(bus.sel), 32'(SEL_NONE));
        check("reset d", 32'(bus.d), 32'd0);
        check("reset ready", 32'(bus.cmd_ready), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Held cmd_valid during a fast ramp (top = 0): no accept until done.
        @(negedge clk);
        drive_cmd(mk(0, 65530, 1, 0, 1'b0, 0, 0, 0, 0, 0, 0));
        check("busy ready", 32'(bus.cmd_ready), 32'd1);
        cyc = 0; nw = 0; n_top = 0; early_ready = 0; seen = 1'b0; last_d = '0;
        while (!seen && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.cmd_top    = W'(99);
                bus.cmd_target = W'(100);
                bus.cmd_step   = W'(10);
                bus.cmd_div    = '0;
            end
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.cmd_ready) early_ready++;
                if (bus.sel == SEL_TOP) n_top++;
                if (bus.sel == SEL_CMP) begin
                    nw++;
                    last_d = bus.d;
                end
            end
        end
        check("busy done_seen", 32'(seen), 32'd1);
        check("busy no_early_ready", 32'(early_ready), 32'd0);
        check("busy no_top_load", 32'(n_top), 32'd0);
        check("busy n_writes", 32'(nw), 32'd3);
        check("busy last_write", 32'(last_d), 32'd65530);
        check("busy ready_with_done", 32'(bus.cmd_ready), 32'd1);

        // The still-held command is accepted on the edge right after done.
        @(negedge clk);
        check("second top_load sel", 32'(bus.sel), 32'(SEL_TOP));
        check("second top_load d", 32'(bus.d), 32'd99);
        check("second busy", 32'(bus.busy), 32'd1);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("second cnt_load sel", 32'(bus.sel), 32'(SEL_CNT));
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.sel == SEL_CMP) begin
                seen = 1'b1;
                last_d = bus.d;
            end
        end
        check("second first_write seen", 32'(seen), 32'd1);
        check("second first_write d", 32'(last_d), 32'd65520);

        // Reset in the middle of the ramp abandons the command.
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst sel", 32'(bus.sel), 32'(SEL_NONE));
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst ready", 32'(bus.cmd_ready), 32'd1);
        check("midrst done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        n_stray = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.sel != SEL_NONE || bus.done) n_stray++;
        end
        check("midrst no_further_writes", 32'(n_stray), 32'd0);

        // cur restarts from 0 after reset: a single step of 30 reaches the target.
        run_vec(mk(99, 30, 30, 0, 1'b0, 1, 30, 0, 0, 0, 0), "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
